// File: rtl/march_bist_sequencer_if.sv
// Bus between the March C- BIST sequencer, its test-mode controller and the RAM port mux.
// master is the sequencer side; slave is the controller/RAM side.
interface march_bist_sequencer_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
);
    logic              start;
    logic [DATA_W-1:0] mem_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic              mem_re;
    logic              busy;
    logic              done;
    logic              fail;
    logic [ADDR_W-1:0] fail_addr;
    logic [DATA_W-1:0] fail_data;
    logic [2:0]        fail_elem;

    modport master (
        input  start, mem_rdata,
        output mem_addr, mem_wdata, mem_we, mem_re,
               busy, done, fail, fail_addr, fail_data, fail_elem
    );

    modport slave (
        output start, mem_rdata,
        input  mem_addr, mem_wdata, mem_we, mem_re,
               busy, done, fail, fail_addr, fail_data, fail_elem
    );
endinterface

// File: rtl/march_bist_sequencer.sv
// March C- BIST sequencer: drives a single-port synchronous RAM through
// {up w0; up r0,w1; up r1,w0; down r0,w1; down r1,w0; up r0} and captures the first failure.
module march_bist_sequencer #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    march_bist_sequencer_if.master  bus
);
    typedef enum logic [3:0] {
        S_IDLE, S_M0, S_M1, S_M2, S_M3, S_M4, S_M5, S_FLUSH, S_DONE
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_FIRST = '0;
    localparam logic [ADDR_W-1:0] ADDR_LAST  = '1;
    localparam logic [ADDR_W-1:0] ADDR_ONE   = ADDR_W'(1);

    state_t            r_state, w_state_next;
    logic              r_phase, w_phase_next;   // 0 = read half, 1 = write half of M1-M4
    logic [ADDR_W-1:0] r_addr, w_addr_next;
    logic              w_up_end, w_dn_end, w_start_ok;

    logic              w_we_next, w_re_next, w_busy_next, w_done_next;
    logic [DATA_W-1:0] w_wdata_next, w_exp_next;
    logic [2:0]        w_elem_next;

    logic              r_mem_we, r_mem_re, r_busy, r_done;
    logic [DATA_W-1:0] r_mem_wdata, r_exp;
    logic [2:0]        r_elem;

    logic              r_cmp_valid, w_mismatch;
    logic [DATA_W-1:0] r_cmp_exp;
    logic [ADDR_W-1:0] r_cmp_addr;
    logic [2:0]        r_cmp_elem;
    logic              r_fail;
    logic [ADDR_W-1:0] r_fail_addr;
    logic [DATA_W-1:0] r_fail_data;
    logic [2:0]        r_fail_elem;

    // Terminal addresses are explicit compares so the counter never wraps past an element end.
    assign w_up_end   = (r_addr == ADDR_LAST);
    assign w_dn_end   = (r_addr == ADDR_FIRST);
    assign w_start_ok = bus.start && (r_state == S_IDLE || r_state == S_DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_phase <= 1'b0;
            r_addr  <= '0;
        end else begin
            r_state <= w_state_next;
            r_phase <= w_phase_next;
            r_addr  <= w_addr_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_phase_next = r_phase;
        w_addr_next  = r_addr;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    w_state_next = S_M0;
                    w_phase_next = 1'b0;
                    w_addr_next  = ADDR_FIRST;
                end
            end
            S_M0: begin
                if (w_up_end) begin
                    w_state_next = S_M1;
                    w_addr_next  = ADDR_FIRST;
                end else begin
                    w_addr_next  = r_addr + ADDR_ONE;
                end
            end
            S_M1, S_M2: begin
                w_phase_next = ~r_phase;
                if (r_phase) begin
                    if (w_up_end) begin
                        w_state_next = (r_state == S_M1) ? S_M2 : S_M3;
                        w_addr_next  = (r_state == S_M1) ? ADDR_FIRST : ADDR_LAST;
                    end else begin
                        w_addr_next  = r_addr + ADDR_ONE;
                    end
                end
            end
            S_M3, S_M4: begin
                w_phase_next = ~r_phase;
                if (r_phase) begin
                    if (w_dn_end) begin
                        w_state_next = (r_state == S_M3) ? S_M4 : S_M5;
                        w_addr_next  = (r_state == S_M3) ? ADDR_LAST : ADDR_FIRST;
                    end else begin
                        w_addr_next  = r_addr - ADDR_ONE;
                    end
                end
            end
            S_M5: begin
                if (w_up_end) begin
                    w_state_next = S_FLUSH;
                end else begin
                    w_addr_next  = r_addr + ADDR_ONE;
                end
            end
            S_FLUSH: w_state_next = S_DONE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Decoded from the next state so every strobe and data word leaves a flop.
    always_comb begin
        w_we_next    = 1'b0;
        w_re_next    = 1'b0;
        w_wdata_next = '0;
        w_exp_next   = '0;
        w_elem_next  = 3'd0;
        w_busy_next  = (w_state_next != S_IDLE) && (w_state_next != S_DONE);
        w_done_next  = (w_state_next == S_DONE);
        case (w_state_next)
            S_M0: w_we_next = 1'b1;
            S_M1, S_M3: begin
                w_elem_next  = (w_state_next == S_M1) ? 3'd1 : 3'd3;
                w_we_next    = w_phase_next;
                w_re_next    = ~w_phase_next;
                w_wdata_next = '1;
            end
            S_M2, S_M4: begin
                w_elem_next  = (w_state_next == S_M2) ? 3'd2 : 3'd4;
                w_we_next    = w_phase_next;
                w_re_next    = ~w_phase_next;
                w_exp_next   = '1;
            end
            S_M5: begin
                w_elem_next  = 3'd5;
                w_re_next    = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem_we    <= 1'b0;
            r_mem_re    <= 1'b0;
            r_mem_wdata <= '0;
            r_exp       <= '0;
            r_elem      <= 3'd0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_mem_we    <= w_we_next;
            r_mem_re    <= w_re_next;
            r_mem_wdata <= w_wdata_next;
            r_exp       <= w_exp_next;
            r_elem      <= w_elem_next;
            r_busy      <= w_busy_next;
            r_done      <= w_done_next;
        end
    end

    // Read data returns one cycle after the strobe, so the expectation rides one stage behind.
    assign w_mismatch = r_cmp_valid && (bus.mem_rdata != r_cmp_exp);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cmp_valid <= 1'b0;
            r_cmp_exp   <= '0;
            r_cmp_addr  <= '0;
            r_cmp_elem  <= 3'd0;
            r_fail      <= 1'b0;
            r_fail_addr <= '0;
            r_fail_data <= '0;
            r_fail_elem <= 3'd0;
        end else begin
            r_cmp_valid <= r_mem_re;
            r_cmp_exp   <= r_exp;
            r_cmp_addr  <= r_addr;
            r_cmp_elem  <= r_elem;
            if (w_start_ok) begin
                r_fail      <= 1'b0;
                r_fail_addr <= '0;
                r_fail_data <= '0;
                r_fail_elem <= 3'd0;
            end else if (w_mismatch) begin
                r_fail <= 1'b1;
                if (!r_fail) begin
                    r_fail_addr <= r_cmp_addr;
                    r_fail_data <= bus.mem_rdata;
                    r_fail_elem <= r_cmp_elem;
                end
            end
        end
    end

    assign bus.mem_addr  = r_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_re    = r_mem_re;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.fail      = r_fail;
    assign bus.fail_addr = r_fail_addr;
    assign bus.fail_data = r_fail_data;
    assign bus.fail_elem = r_fail_elem;
endmodule

// File: tb/tb_march_bist_sequencer.sv
// Scoreboard bench for march_bist_sequencer: a march-level reference model queues the expected
// access trace and final result per run; a negedge monitor pops and compares against the DUT.
module tb_march_bist_sequencer;
    localparam int N = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    march_bist_sequencer_if #(.ADDR_W(4), .DATA_W(8)) bus ();

    march_bist_sequencer #(.ADDR_W(4), .DATA_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [7:0] ram   [N];
    logic [7:0] f_or  [N];
    logic [7:0] f_and [N];

    // RAM with stuck-at faults applied on the read path.
    always @(posedge clk) begin
        if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
        if (bus.mem_re) bus.mem_rdata <= (ram[bus.mem_addr] | f_or[bus.mem_addr]) & f_and[bus.mem_addr];
    end

    typedef struct packed {
        logic       we;
        logic [3:0] addr;
        logic [7:0] data;
    } acc_t;

    typedef struct packed {
        logic        fail;
        logic [3:0]  addr;
        logic [7:0]  data;
        logic [2:0]  elem;
        logic [31:0] cyc;
    } res_t;

    acc_t       acc_q[$];
    res_t       res_q[$];
    logic [7:0] model_mem [N];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: walk the March C- element list over an abstract faulty memory.
    task automatic model_push();
        logic [7:0] m [N];
        res_t r;
        int   cyc;
        int   dir  [6] = '{0, 0, 0, 1, 1, 0};
        int   nops [6] = '{1, 2, 2, 2, 2, 1};
        bit   opw  [6][2] = '{'{1, 0}, '{0, 1}, '{0, 1}, '{0, 1}, '{0, 1}, '{0, 0}};
        bit   opv  [6][2] = '{'{0, 0}, '{0, 1}, '{1, 0}, '{0, 1}, '{1, 0}, '{0, 0}};
        r   = '0;
        cyc = 0;
        for (int e = 0; e < 6; e++) begin
            for (int i = 0; i < N; i++) begin
                int a;
                a = (dir[e] != 0) ? (N - 1 - i) : i;
                for (int o = 0; o < nops[e]; o++) begin
                    logic [7:0] v, obs;
                    v = opv[e][o] ? 8'hFF : 8'h00;
                    if (opw[e][o]) begin
                        m[a] = v;
                        acc_q.push_back({1'b1, 4'(a), v});
                    end else begin
                        acc_q.push_back({1'b0, 4'(a), v});
                        obs = (m[a] | f_or[a]) & f_and[a];
                        if (obs != v && !r.fail) begin
                            r.fail = 1'b1;
                            r.addr = 4'(a);
                            r.data = obs;
                            r.elem = 3'(e);
                            r.cyc  = 32'(cyc + 2);
                        end
                    end
                    cyc++;
                end
            end
        end
        for (int i = 0; i < N; i++) model_mem[i] = m[i];
        res_q.push_back(r);
    endtask

    // Monitor: decoupled from stimulus, checks every cycle.
    logic pb, pd, pf;
    int   run_cyc, busy_cnt, fail_cyc;

    always @(negedge clk) begin
        if (rst) begin
            pb = 1'b0;
            pd = 1'b0;
            pf = 1'b0;
        end else begin
            if (bus.busy && !pb) begin
                run_cyc  = 0;
                busy_cnt = 0;
                fail_cyc = -1;
                chk("start_clears", {bus.done, bus.fail, bus.fail_addr, bus.fail_data, bus.fail_elem}, 32'h0);
            end else begin
                run_cyc++;
            end
            if (bus.busy) busy_cnt++;
            if (bus.mem_we || bus.mem_re) begin
                chk("strobe_in_busy", {31'h0, bus.busy}, 32'h1);
                chk("we_re_exclusive", {31'h0, bus.mem_we & bus.mem_re}, 32'h0);
                if (acc_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_access: got addr %0h we=%0b expected no access", bus.mem_addr, bus.mem_we);
                end else begin
                    acc_t e;
                    e = acc_q.pop_front();
                    chk("access_op_addr", {bus.mem_we, bus.mem_re, bus.mem_addr}, {e.we, ~e.we, e.addr});
                    if (bus.mem_we) chk("access_wdata", bus.mem_wdata, e.data);
                end
            end
            if (bus.fail && !pf) fail_cyc = run_cyc;
            if (bus.done && !pd) begin
                if (res_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_done: got done expected no completion");
                end else begin
                    res_t r;
                    r = res_q.pop_front();
                    chk("busy_length", busy_cnt, 32'd161);
                    chk("busy_at_done", {31'h0, bus.busy}, 32'h0);
                    chk("trace_consumed", acc_q.size(), 32'h0);
                    chk("fail_flag", {31'h0, bus.fail}, {31'h0, r.fail});
                    if (r.fail) begin
                        chk("fail_addr", bus.fail_addr, r.addr);
                        chk("fail_data", bus.fail_data, r.data);
                        chk("fail_elem", bus.fail_elem, r.elem);
                        chk("fail_timing", fail_cyc, r.cyc);
                    end
                end
            end
            pb = bus.busy;
            pd = bus.done;
            pf = bus.fail;
        end
    end

    function automatic logic [31:0] all_outputs();
        return {bus.mem_addr, bus.mem_wdata, bus.mem_we, bus.mem_re, bus.busy, bus.done,
                bus.fail, bus.fail_addr, bus.fail_data, bus.fail_elem};
    endfunction

    task automatic clear_faults();
        for (int i = 0; i < N; i++) begin
            f_or[i]  = 8'h00;
            f_and[i] = 8'hFF;
        end
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic run(input string label, input bit mid_start);
        int n;
        model_push();
        pulse_start();
        if (mid_start) begin
            repeat (19) @(posedge clk);
            #1;
            pulse_start();
        end
        n = 0;
        while (!bus.done && n < 400) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({label, "_done_seen"}, {31'h0, bus.done}, 32'h1);
        @(posedge clk);
        #1;
        if (!bus.done) begin
            acc_q.delete();
            res_q.delete();
        end
        for (int i = 0; i < N; i++) chk({label, "_ram_content"}, ram[i], model_mem[i]);
        $display("run %s: fail=%0b elem=%0d addr=%0d data=%02h", label, bus.fail,
                 bus.fail_elem, bus.fail_addr, bus.fail_data);
    endtask

    initial begin
        rst       = 1'b1;
        bus.start = 1'b0;
        clear_faults();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", all_outputs(), 32'h0);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        run("clean", 1'b0);

        f_or[0] = 8'h01;
        run("sa1_a0_b0", 1'b0);
        clear_faults();

        f_and[5] = 8'hF7;
        run("sa0_a5_b3", 1'b0);
        clear_faults();

        run("restart_mid_start", 1'b1);

        // Abort in M2 with a fault present, then a fresh complete run.
        f_or[3] = 8'h80;
        model_push();
        pulse_start();
        repeat (55) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("reset_mid_run_outputs", all_outputs(), 32'h0);
        acc_q.delete();
        res_q.delete();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("idle_after_reset", {bus.busy, bus.done, bus.mem_we, bus.mem_re}, 32'h0);
        $display("run reset_mid_run: aborted in M2");
        clear_faults();
        run("after_reset", 1'b0);

        for (int k = 0; k < 4; k++) begin
            int nf;
            clear_faults();
            nf = $urandom_range(0, 2);
            for (int j = 0; j < nf; j++) begin
                int a, b;
                a = $urandom_range(0, N - 1);
                b = $urandom_range(0, 7);
                if ($urandom_range(0, 1) != 0) f_or[a]  = f_or[a]  | (8'h01 << b);
                else                           f_and[a] = f_and[a] & ~(8'h01 << b);
            end
            run($sformatf("random%0d", k), ($urandom_range(0, 1) != 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
